// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer:
// op codes, FSM states, unit select and the watchdog default.
package muldiv_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_ARM   = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    localparam logic U_MUL = 1'b0;
    localparam logic U_DIV = 1'b1;

    localparam int TIMEOUT_DEF = 64;

    function automatic logic op_is_mul(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic op_is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_hilo.sv
// Architectural HI/LO pair: unit results take priority over MTHI/MTLO,
// and the MFHI/MFLO read path is purely combinational.
module muldiv_hilo
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic        mul_done,
    input  logic        div_done,
    input  logic [31:0] rs_data,
    input  logic [63:0] mul_z,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic        rd_hi,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data
);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (mul_done) begin
            hi_d = mul_z[63:32];
            lo_d = mul_z[31:0];
        end else if (div_done) begin
            hi_d = div_r;
            lo_d = div_q;
        end else begin
            if (we_hi) hi_d = rs_data;
            if (we_lo) lo_d = rs_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign mf_data = rd_hi ? hi_q : lo_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer for the iterative multiplier/divider; owns HI/LO
// and stalls the pipeline while a unit is occupied.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CW      = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [3:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        stall,
    output logic [31:0] mf_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero,
    output logic        timeout_err,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_sign,
    output logic        mul_start,
    input  logic [63:0] mul_z,
    input  logic        mul_busy,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_sign,
    output logic        div_start,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic        div_busy
);

    logic [1:0]    state_q, state_d;
    logic          unit_q, unit_d;
    logic [CW-1:0] wd_q, wd_d;
    logic [31:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [31:0]   div_a_q, div_a_d, div_b_q, div_b_d;
    logic          mul_sign_q, mul_sign_d, div_sign_q, div_sign_d;
    logic          dbz_q, dbz_d, to_q, to_d;
    logic          accept, sel_busy, mul_done, div_done;

    assign accept   = op_valid && (state_q == S_IDLE);
    assign stall    = op_valid && (state_q != S_IDLE);
    assign sel_busy = (unit_q == U_DIV) ? div_busy : mul_busy;

    always_comb begin
        state_d    = state_q;
        unit_d     = unit_q;
        wd_d       = wd_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        mul_sign_d = mul_sign_q;
        div_a_d    = div_a_q;
        div_b_d    = div_b_q;
        div_sign_d = div_sign_q;
        dbz_d      = 1'b0;
        to_d       = to_q;
        mul_done   = 1'b0;
        div_done   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept && op_is_mul(op)) begin
                    mul_a_d    = rs_data;
                    mul_b_d    = rt_data;
                    mul_sign_d = (op == OP_MULT);
                    unit_d     = U_MUL;
                    state_d    = S_START;
                end else if (accept && op_is_div(op)) begin
                    if (rt_data == '0) begin
                        dbz_d = 1'b1;
                    end else begin
                        div_a_d    = rs_data;
                        div_b_d    = rt_data;
                        div_sign_d = (op == OP_DIV);
                        unit_d     = U_DIV;
                        state_d    = S_START;
                    end
                end
            end
            S_START: state_d = S_ARM;
            // busy may not have risen yet, so it is not sampled here
            S_ARM: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + CW'(1);
                if (!sel_busy) begin
                    mul_done = (unit_q == U_MUL);
                    div_done = (unit_q == U_DIV);
                    state_d  = S_IDLE;
                end else if (wd_q == CW'(TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            unit_q     <= U_MUL;
            wd_q       <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_sign_q <= 1'b0;
            div_a_q    <= '0;
            div_b_q    <= '0;
            div_sign_q <= 1'b0;
            dbz_q      <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            unit_q     <= unit_d;
            wd_q       <= wd_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            mul_sign_q <= mul_sign_d;
            div_a_q    <= div_a_d;
            div_b_q    <= div_b_d;
            div_sign_q <= div_sign_d;
            dbz_q      <= dbz_d;
            to_q       <= to_d;
        end
    end

    assign mul_start   = (state_q == S_START) && (unit_q == U_MUL);
    assign div_start   = (state_q == S_START) && (unit_q == U_DIV);
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign mul_sign    = mul_sign_q;
    assign div_a       = div_a_q;
    assign div_b       = div_b_q;
    assign div_sign    = div_sign_q;
    assign div_by_zero = dbz_q;
    assign timeout_err = to_q;

    muldiv_hilo u_hilo (
        .clk      (clk),
        .reset    (reset),
        .we_hi    (accept && (op == OP_MTHI)),
        .we_lo    (accept && (op == OP_MTLO)),
        .mul_done (mul_done),
        .div_done (div_done),
        .rs_data  (rs_data),
        .mul_z    (mul_z),
        .div_q    (div_q),
        .div_r    (div_r),
        .rd_hi    (op == OP_MFHI),
        .hi       (hi),
        .lo       (lo),
        .mf_data  (mf_data)
    );

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer for the CPU's multi-cycle multiply/divide resources. Sits in the EX stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO micro-ops, launches the external iterative multiplier or divider, and waits for completion. It owns the architectural HI/LO registers and stalls the pipeline while the unit is occupied.

Parameters:
TIMEOUT, 64, max cycles in WAIT before abort; must exceed worst-case multiplier/divider latency (~34).
CW, 7, width of the watchdog counter; 2**CW > TIMEOUT.

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
op_valid  in  1  EX stage presents a mul/div-class op
op  in  4  op code (see package)
rs_data  in  32  operand A / MTHI-MTLO source
rt_data  in  32  operand B
stall  out  1  hold IF/ID/EX; op not accepted this cycle
mf_data  out  32  MFHI/MFLO result, combinational
hi  out  32  architectural HI
lo  out  32  architectural LO
div_by_zero  out  1  one-cycle pulse, DIV/DIVU with rt_data==0
timeout_err  out  1  sticky until reset, watchdog fired
mul_a, mul_b  out  32 each  multiplier operands (registered)
mul_sign  out  1  1=signed
mul_start  out  1  one-cycle launch pulse
mul_z  in  64  multiplier product
mul_busy  in  1  multiplier running
div_a, div_b  out  32 each  dividend/divisor (registered)
div_sign  out  1  1=signed
div_start  out  1  one-cycle launch pulse
div_q, div_r  in  32 each  quotient/remainder
div_busy  in  1  divider running

Behaviour:
- Reset (sync, any state, including mid-operation): state=IDLE; hi=lo=0; mul_/div_start=0; operand/sign regs=0; watchdog=0; div_by_zero=0; timeout_err=0. An in-flight result is discarded.
- FSM states: IDLE, START, ARM, WAIT.
- accept = op_valid & state==IDLE. stall = op_valid & state!=IDLE. Any op arriving while the unit is occupied stalls, including MF*/MT*. Non-mul/div instructions are never stalled by this block.
- IDLE, accepted op:
  - MULT/MULTU: latch rs/rt into mul_a/mul_b; mul_sign=(op==MULT); unit_sel=MUL; go to START.
  - DIV/DIVU with rt_data!=0: same path on the div_ port set.
  - DIV/DIVU with rt_data==0: stay IDLE; div_by_zero=1 next cycle for one cycle; HI/LO unchanged.
  - MTHI/MTLO: hi/lo <= rs_data at this edge; stay IDLE.
  - MFHI/MFLO: mf_data = hi/lo combinationally in the same cycle; no state change.
  - NOP: ignored.
- START (1 cycle): selected *_start=1, other start=0. Go to ARM.
- ARM (1 cycle): busy is ignored, to cover the busy-rise latency. Go to WAIT; clear watchdog.
- WAIT: watchdog increments each cycle.
  - Selected busy==0: MUL writes hi<=mul_z[63:32], lo<=mul_z[31:0]. DIV writes lo<=div_q, hi<=div_r. Go to IDLE. The following op is accepted the next cycle.
  - watchdog==TIMEOUT-1 with busy still high: timeout_err<=1; HI/LO unchanged; go to IDLE.
- Operand/sign registers hold stable from START until return to IDLE.
- Start pulses are never asserted outside START. Never more than one unit is launched at a time.
- op codes outside the defined set are treated as NOP.
- Minimum MULT latency: accept at cycle 0, START at 1, ARM at 2, HI/LO valid after the first WAIT edge with busy low.

Decomposition:
- Package muldiv_pkg holds the op encoding: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
- The package also holds the state enum {IDLE, START, ARM, WAIT}, unit_sel {MUL, DIV}, and the TIMEOUT default.
- One natural sub-module: muldiv_hilo, the HI/LO register pair with write mux (MT*, mul result, div result) and MF read mux.

Test Plan:
- MULT rs=0xFFFFFFFF, rt=0x00000002 with the real multiplier -> one mul_start pulse, mul_sign=1; after done hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU same operands -> mul_sign=0; hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MFLO presented the cycle after MULT is accepted -> stall=1 until return to IDLE; then mf_data equals the new lo and stall drops.
- DIVU rt=0 with prior hi=0x1234, lo=0x5678 -> no div_start; div_by_zero pulses exactly one cycle; hi/lo unchanged; stall never asserted.
- Stub mul_busy stuck high -> timeout_err=1 after TIMEOUT WAIT cycles, FSM back to IDLE. Separately, reset asserted mid-WAIT -> next cycle state IDLE, hi=lo=0, stall=0.
